// File: rtl/nand10_match_filter.sv
// Qualifies the active-low NAND10 output into a debounced MATCH with
// programmable assert/release run lengths, edge pulses and a saturating event count.
module nand10_match_filter #(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2,
  parameter int unsigned CNT_WIDTH  = 4,
  parameter int unsigned EV_WIDTH   = 8
) (
  input  logic                CK,
  input  logic                CD,
  input  logic                CE,
  input  logic                ZN,
  input  logic                EVCLR,
  output logic                MATCH,
  output logic                MRISE,
  output logic                MFALL,
  output logic                PEND,
  output logic [EV_WIDTH-1:0] EVCNT
);

  typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, DROP} state_t;

  localparam logic [CNT_WIDTH:0] ON_N  = (CNT_WIDTH+1)'(ON_CYCLES);
  localparam logic [CNT_WIDTH:0] OFF_N = (CNT_WIDTH+1)'(OFF_CYCLES);

  state_t               state, state_nxt;
  logic                 s;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic                 rise, fall;

  // One extra bit so the equality test against the run length cannot alias.
  assign cnt_inc = {1'b0, cnt} + (CNT_WIDTH+1)'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise      = 1'b0;
    fall      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (s) begin
          if (ON_CYCLES == 1) begin
            state_nxt = ACTIVE;
            rise      = 1'b1;
          end else begin
            state_nxt = QUAL;
            cnt_nxt   = CNT_WIDTH'(1);
          end
        end
      end
      QUAL: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc == ON_N) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          rise      = 1'b1;
        end else begin
          cnt_nxt = cnt_inc[CNT_WIDTH-1:0];
        end
      end
      ACTIVE: begin
        cnt_nxt = '0;
        if (!s) begin
          if (OFF_CYCLES == 1) begin
            state_nxt = IDLE;
            fall      = 1'b1;
          end else begin
            state_nxt = DROP;
            cnt_nxt   = CNT_WIDTH'(1);
          end
        end
      end
      DROP: begin
        if (s) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
        end else if (cnt_inc == OFF_N) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          fall      = 1'b1;
        end else begin
          cnt_nxt = cnt_inc[CNT_WIDTH-1:0];
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      MATCH <= 1'b0;
      MRISE <= 1'b0;
      MFALL <= 1'b0;
      PEND  <= 1'b0;
      EVCNT <= '0;
    end else begin
      // Pulses self-clear even while CE is low so they stay one CK cycle wide.
      MRISE <= 1'b0;
      MFALL <= 1'b0;
      if (CE) begin
        s     <= ~ZN;
        state <= state_nxt;
        cnt   <= cnt_nxt;
        MATCH <= (state_nxt == ACTIVE) || (state_nxt == DROP);
        PEND  <= (state_nxt == QUAL) || (state_nxt == DROP);
        MRISE <= rise;
        MFALL <= fall;
      end
      if (EVCLR)
        EVCNT <= (CE && rise) ? EV_WIDTH'(1) : '0;
      else if (CE && rise && (EVCNT != '1))
        EVCNT <= EVCNT + EV_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_nand10_match_filter.sv
// Directed bench: default parameters, a 2-bit event counter, and ON=OFF=1.
module tb_nand10_match_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Instance A: ON=4, OFF=2, EV_WIDTH=8
  logic a_cd = 1'b1, a_ce = 1'b1, a_zn = 1'b0, a_evclr = 1'b0;
  logic a_match, a_mrise, a_mfall, a_pend;
  logic [7:0] a_evcnt;
  nand10_match_filter #(.ON_CYCLES(4), .OFF_CYCLES(2), .CNT_WIDTH(4), .EV_WIDTH(8)) dut_a (
    .CK(clk), .CD(a_cd), .CE(a_ce), .ZN(a_zn), .EVCLR(a_evclr),
    .MATCH(a_match), .MRISE(a_mrise), .MFALL(a_mfall), .PEND(a_pend), .EVCNT(a_evcnt));

  // Instance B: EV_WIDTH=2 saturation
  logic b_cd = 1'b1, b_ce = 1'b1, b_zn = 1'b1, b_evclr = 1'b0;
  logic b_match, b_mrise, b_mfall, b_pend;
  logic [1:0] b_evcnt;
  nand10_match_filter #(.ON_CYCLES(4), .OFF_CYCLES(2), .CNT_WIDTH(4), .EV_WIDTH(2)) dut_b (
    .CK(clk), .CD(b_cd), .CE(b_ce), .ZN(b_zn), .EVCLR(b_evclr),
    .MATCH(b_match), .MRISE(b_mrise), .MFALL(b_mfall), .PEND(b_pend), .EVCNT(b_evcnt));

  // Instance C: ON=1, OFF=1
  logic c_cd = 1'b1, c_ce = 1'b1, c_zn = 1'b1, c_evclr = 1'b0;
  logic c_match, c_mrise, c_mfall, c_pend;
  logic [7:0] c_evcnt;
  nand10_match_filter #(.ON_CYCLES(1), .OFF_CYCLES(1), .CNT_WIDTH(4), .EV_WIDTH(8)) dut_c (
    .CK(clk), .CD(c_cd), .CE(c_ce), .ZN(c_zn), .EVCLR(c_evclr),
    .MATCH(c_match), .MRISE(c_mrise), .MFALL(c_mfall), .PEND(c_pend), .EVCNT(c_evcnt));

  logic [15:0] c_pat;
  logic        prev_s, exp_m, prev_m;
  logic [7:0]  exp_ev;

  initial begin
    // ---------------- Instance A ----------------
    tick(2);
    chk("rst_match", a_match, 0);
    chk("rst_mrise", a_mrise, 0);
    chk("rst_mfall", a_mfall, 0);
    chk("rst_pend",  a_pend,  0);
    chk("rst_evcnt", a_evcnt, 0);

    a_cd = 1'b0; a_zn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_match", a_match, 0);
    end
    chk("idle_evcnt", a_evcnt, 0);

    // Qualified assert: edge 0 captures ZN=0
    a_zn = 1'b0;
    tick(1);
    chk("e0_pend", a_pend, 0);
    tick(1);
    chk("e1_pend", a_pend, 1);
    chk("e1_match", a_match, 0);
    tick(2);
    chk("e3_match", a_match, 0);
    chk("e3_pend", a_pend, 1);
    tick(1);
    chk("e4_match", a_match, 1);
    chk("e4_mrise", a_mrise, 1);
    chk("e4_pend", a_pend, 0);
    chk("e4_evcnt", a_evcnt, 1);
    tick(1);
    chk("e5_mrise", a_mrise, 0);
    chk("e5_match", a_match, 1);
    tick(4);
    // Deassert: edge 10 captures ZN=1
    a_zn = 1'b1;
    tick(1);
    chk("e10_match", a_match, 1);
    tick(1);
    chk("e11_match", a_match, 1);
    chk("e11_pend", a_pend, 1);
    chk("e11_mfall", a_mfall, 0);
    tick(1);
    chk("e12_match", a_match, 0);
    chk("e12_mfall", a_mfall, 1);
    chk("e12_pend", a_pend, 0);
    tick(1);
    chk("e13_mfall", a_mfall, 0);

    // Glitch reject: three low samples are one short of ON_CYCLES
    a_zn = 1'b0;
    tick(3);
    a_zn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("glitch_match", a_match, 0);
      chk("glitch_mrise", a_mrise, 0);
    end
    chk("glitch_pend", a_pend, 0);
    chk("glitch_evcnt", a_evcnt, 1);

    // One-cycle dropout while ACTIVE
    a_zn = 1'b0;
    tick(7);
    chk("act2_match", a_match, 1);
    chk("act2_evcnt", a_evcnt, 2);
    a_zn = 1'b1;
    tick(1);
    a_zn = 1'b0;
    tick(1);
    chk("dropout_pend", a_pend, 1);
    chk("dropout_match", a_match, 1);
    chk("dropout_mfall", a_mfall, 0);
    tick(1);
    chk("recover_pend", a_pend, 0);
    chk("recover_match", a_match, 1);
    chk("recover_mfall", a_mfall, 0);
    a_zn = 1'b1;
    tick(3);
    chk("exit2_match", a_match, 0);
    chk("exit2_mfall", a_mfall, 1);
    tick(1);

    // CE hold during QUAL with cnt=2
    a_zn = 1'b0;
    tick(3);
    chk("ce_pre_pend", a_pend, 1);
    a_ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_zn = i[0];
      tick(1);
      chk("ce_hold_pend", a_pend, 1);
      chk("ce_hold_match", a_match, 0);
    end
    a_ce = 1'b1; a_zn = 1'b0;
    tick(1);
    chk("ce_r1_match", a_match, 0);
    tick(1);
    chk("ce_r2_match", a_match, 1);
    chk("ce_r2_mrise", a_mrise, 1);
    chk("ce_r2_evcnt", a_evcnt, 3);
    a_ce = 1'b0;
    tick(1);
    chk("ce_pulse_clr", a_mrise, 0);
    chk("ce_off_match", a_match, 1);
    a_ce = 1'b1;

    // EVCLR on the MRISE-firing edge loads 1
    a_zn = 1'b1;
    tick(4);
    chk("exit3_match", a_match, 0);
    a_zn = 1'b0;
    tick(4);
    a_evclr = 1'b1;
    tick(1);
    a_evclr = 1'b0;
    chk("evclr_rise_mrise", a_mrise, 1);
    chk("evclr_rise_evcnt", a_evcnt, 1);
    a_ce = 1'b0; a_evclr = 1'b1;
    tick(1);
    chk("evclr_noce_evcnt", a_evcnt, 0);
    a_ce = 1'b1; a_evclr = 1'b0;

    // Reset while MATCH=1
    tick(1);
    chk("pre_rst_match", a_match, 1);
    a_cd = 1'b1;
    tick(1);
    chk("midrst_match", a_match, 0);
    chk("midrst_mfall", a_mfall, 0);
    chk("midrst_pend", a_pend, 0);
    a_cd = 1'b0;
    tick(1);
    chk("postrst_mfall", a_mfall, 0);
    chk("postrst_match", a_match, 0);

    // ---------------- Instance B ----------------
    tick(1);
    b_cd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_zn = 1'b0;
      tick(6);
      chk("sat_match", b_match, 1);
      chk("sat_evcnt", b_evcnt, (i + 1 > 3) ? 3 : i + 1);
      b_zn = 1'b1;
      tick(4);
      chk("sat_release", b_match, 0);
    end

    // ---------------- Instance C ----------------
    c_cd = 1'b0;
    c_pat  = 16'b0110_0010_1101_0001;
    prev_s = 1'b0;
    prev_m = 1'b0;
    exp_ev = 8'd0;
    for (int i = 0; i < 16; i++) begin
      c_zn = c_pat[i];
      tick(1);
      exp_m = prev_s;
      if (exp_m && !prev_m) exp_ev++;
      chk("one_match", c_match, exp_m);
      chk("one_mrise", c_mrise, exp_m & ~prev_m);
      chk("one_mfall", c_mfall, ~exp_m & prev_m);
      chk("one_pend",  c_pend, 0);
      prev_m = exp_m;
      prev_s = ~c_zn;
    end
    chk("one_evcnt", c_evcnt, exp_ev);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
